// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell. Purely combinational. It is the unit that the ripple
// chain in ripple_carry_adder is built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
// Sum, Cout and Ovf are registered, so results appear with one cycle of latency.
//
// Valid semantics: in_valid qualifies A, B and Cin on the rising edge where it is
// sampled. out_valid is high for exactly one cycle after each such edge. There is
// no ready signal and no backpressure. When in_valid is low, out_valid drops and
// the result registers keep their last value.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = carry[WIDTH];
      // Signed overflow: the carry into the MSB differs from the carry out of it.
      ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed-vector bench for ripple_carry_adder at WIDTH=4. Inputs are driven on the
// falling edge and outputs are sampled on the next falling edge.
module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout, ovf, out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf),
    .out_valid (out_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  // scoreboard queue entry layout: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc);
    in_valid = v;
    a        = va;
    b        = vb;
    cin      = vc;
  endtask

  // Reference model: a plain integer add, with overflow taken from the operand and
  // result sign bits.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0] full;
    logic       o;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    o    = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    return {o, full};
  endfunction

  task automatic check_result(input string name, input logic [W+1:0] e, input logic ev);
    check({name, ".sum"},       {28'd0, sum}, {28'd0, e[W-1:0]});
    check({name, ".cout"},      {31'd0, cout}, {31'd0, e[W]});
    check({name, ".ovf"},       {31'd0, ovf}, {31'd0, e[W+1]});
    check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W+1:0] last_e;

    vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{4'd1,  4'd1,  1'b0, 4'd2,  1'b0, 1'b0};
    vecs[2] = '{4'd2,  4'd3,  1'b0, 4'd5,  1'b0, 1'b0};
    vecs[3] = '{4'd4,  4'd4,  1'b0, 4'd8,  1'b0, 1'b1};
    vecs[4] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b0, 1'b1};
    vecs[5] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0};
    vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[7] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
    vecs[8] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};

    // Reset is held for two edges while a valid operation is presented.
    rst = 1'b1;
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    @(negedge clk);
    check_result("reset_edge1", '0, 1'b0);
    @(negedge clk);
    check_result("reset_edge2", '0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 4'd9, 4'd9, 1'b0);
    @(negedge clk);
    check_result("post_reset_idle", '0, 1'b0);

    // Directed table, one vector at a time with an idle cycle in between.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      check_result($sformatf("vec%0d", i),
                   {vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum}, 1'b1);
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      check_result($sformatf("vec%0d_hold", i),
                   {vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum}, 1'b0);
    end

    // All 512 input combinations back to back.
    exp_q.delete();
    for (int n = 0; n < 512; n++) begin
      drive(1'b1, n[8:5], n[4:1], n[0]);
      exp_q.push_back(model(n[8:5], n[4:1], n[0]));
      @(negedge clk);
      e = exp_q.pop_front();
      check_result($sformatf("sweep%0d", n), e, 1'b1);
      last_e = e;
    end

    // Removing in_valid drops out_valid and holds the last result.
    drive(1'b0, 4'd3, 4'd5, 1'b1);
    @(negedge clk);
    check_result("drop_valid", last_e, 1'b0);
    @(negedge clk);
    check_result("drop_valid_hold2", last_e, 1'b0);

    // Reset in the middle of a stream: the edge clears the outputs.
    drive(1'b1, 4'd6, 4'd7, 1'b0);
    @(negedge clk);
    check_result("stream_pre_rst", model(4'd6, 4'd7, 1'b0), 1'b1);
    rst = 1'b1;
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    @(negedge clk);
    check_result("mid_stream_rst", '0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 4'd5, 4'd12, 1'b1);
    @(negedge clk);
    check_result("after_rst", model(4'd5, 4'd12, 1'b1), 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
